// File: rtl/data_mask_engine.sv
`default_nettype none
// ============================================================================
// Module      : data_mask_engine
// Description : Collects TRNG words into a DATA_WIDTH mask and XORs it onto a
//               valid/ready data stream through a registered output stage.
//               Optional plaintext parity output: DATA_MASK_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mask_engine #(
    parameter int DATA_WIDTH = 52,
    parameter int TRNG_WIDTH = 32,
    parameter int MASK_REUSE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TRNG_WIDTH-1:0] trng,
    input  logic                  trng_valid,
    output logic                  trng_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_bypass,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] out_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef DATA_MASK_PARITY_EN
    output logic                  out_parity,
`endif
    output logic                  mask_armed
);

    localparam int c_WORDS = (DATA_WIDTH + TRNG_WIDTH - 1) / TRNG_WIDTH;
    localparam int c_PADW  = c_WORDS * TRNG_WIDTH;
    localparam int c_WCW   = $clog2(c_WORDS + 1);
    localparam int c_UCW   = $clog2(MASK_REUSE + 1);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [c_WCW-1:0]        word_cnt_q,  word_cnt_d;
    logic [c_UCW-1:0]        use_cnt_q,   use_cnt_d;
    logic [DATA_WIDTH-1:0]   mask_q,      mask_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [DATA_WIDTH-1:0]   out_mask_q,  out_mask_d;
`ifdef DATA_MASK_PARITY_EN
    logic                    parity_q,    parity_d;
`endif

    logic                    w_beat;
    logic                    w_in_ready;
    logic                    w_xfer;
    logic [c_PADW-1:0]       w_fill;

    assign w_beat     = (state_q == S_FILL) && trng_valid;
    assign w_in_ready = (state_q == S_ARMED) && (!out_valid_q || out_ready);
    assign w_xfer     = in_valid && w_in_ready;

    // Mask zero-extended to whole TRNG lanes with the incoming beat merged
    // into the lane selected by word_cnt; bits above DATA_WIDTH are dropped.
    always_comb begin
        w_fill                 = '0;
        w_fill[DATA_WIDTH-1:0] = mask_q;
        for (int k = 0; k < c_WORDS; k++) begin
            if (word_cnt_q == c_WCW'(k)) begin
                w_fill[k*TRNG_WIDTH +: TRNG_WIDTH] = trng;
            end
        end
    end

    generate
        if (c_PADW > DATA_WIDTH) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^w_fill[c_PADW-1:DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        use_cnt_d   = use_cnt_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
`ifdef DATA_MASK_PARITY_EN
        parity_d    = parity_q;
`endif

        if (w_beat) begin
            mask_d = w_fill[DATA_WIDTH-1:0];
            if (word_cnt_q == c_WCW'(c_WORDS - 1)) begin
                state_d    = S_ARMED;
                word_cnt_d = '0;
                use_cnt_d  = '0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        if (w_xfer) begin
            out_valid_d = 1'b1;
`ifdef DATA_MASK_PARITY_EN
            parity_d    = ^in_data;
`endif
            if (in_bypass) begin
                out_data_d = in_data;
                out_mask_d = '0;
            end else begin
                out_data_d = in_data ^ mask_q;
                out_mask_d = mask_q;
                // Last permitted use of this mask sends the engine back to refill.
                if (use_cnt_q == c_UCW'(MASK_REUSE - 1)) begin
                    state_d    = S_FILL;
                    use_cnt_d  = '0;
                    word_cnt_d = '0;
                end else begin
                    use_cnt_d = use_cnt_q + 1'b1;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            word_cnt_q  <= '0;
            use_cnt_q   <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
`ifdef DATA_MASK_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            use_cnt_q   <= use_cnt_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
`ifdef DATA_MASK_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign trng_ready = (state_q == S_FILL);
    assign in_ready   = w_in_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_mask   = out_mask_q;
    assign mask_armed = (state_q == S_ARMED);
`ifdef DATA_MASK_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mask_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mask_engine
// Description : Directed self-checking bench for data_mask_engine, covering a
//               MASK_REUSE=1 instance and a MASK_REUSE=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mask_engine;

    localparam int DW = 52;
    localparam int TW = 32;

    logic          clk;
    int            n_vec;
    int            n_bad;

    logic          rst_n, trng_valid, trng_ready, in_bypass, in_valid, in_ready;
    logic          out_valid, out_ready, mask_armed;
    logic [TW-1:0] trng;
    logic [DW-1:0] in_data, out_data, out_mask;

    logic          rst4_n, trng4_valid, trng4_ready, in4_bypass, in4_valid, in4_ready;
    logic          out4_valid, out4_ready, mask4_armed;
    logic [TW-1:0] trng4;
    logic [DW-1:0] in4_data, out4_data, out4_mask;
`ifdef DATA_MASK_PARITY_EN
    logic          out_parity, out4_parity;
`endif

    data_mask_engine #(.DATA_WIDTH(DW), .TRNG_WIDTH(TW), .MASK_REUSE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .trng(trng), .trng_valid(trng_valid),
        .trng_ready(trng_ready), .in_data(in_data), .in_bypass(in_bypass),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_mask(out_mask), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DATA_MASK_PARITY_EN
        .out_parity(out_parity),
`endif
        .mask_armed(mask_armed)
    );

    data_mask_engine #(.DATA_WIDTH(DW), .TRNG_WIDTH(TW), .MASK_REUSE(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .trng(trng4), .trng_valid(trng4_valid),
        .trng_ready(trng4_ready), .in_data(in4_data), .in_bypass(in4_bypass),
        .in_valid(in4_valid), .in_ready(in4_ready), .out_data(out4_data),
        .out_mask(out4_mask), .out_valid(out4_valid), .out_ready(out4_ready),
`ifdef DATA_MASK_PARITY_EN
        .out_parity(out4_parity),
`endif
        .mask_armed(mask4_armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic fill0(input logic [TW-1:0] w0, input logic [TW-1:0] w1);
        trng_valid = 1'b1;
        trng       = w0;
        step();
        trng       = w1;
        step();
        trng_valid = 1'b0;
    endtask

    task automatic fill4(input logic [TW-1:0] w0, input logic [TW-1:0] w1);
        trng4_valid = 1'b1;
        trng4       = w0;
        step();
        trng4       = w1;
        step();
        trng4_valid = 1'b0;
    endtask

    localparam logic [DW-1:0] M1 = 52'hA5A5ADEADBEEF;
    localparam logic [DW-1:0] M3 = 52'h2222211111111;
    localparam logic [DW-1:0] M4 = 52'h9ABCD12345678;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0; trng = '0; trng_valid = 1'b0; in_data = '0;
        in_bypass = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rst4_n = 1'b0; trng4 = '0; trng4_valid = 1'b0; in4_data = '0;
        in4_bypass = 1'b0; in4_valid = 1'b0; out4_ready = 1'b1;
        step();
        step();

        check_vec("rst_out_valid",  {63'd0, out_valid},  64'd0);
        check_vec("rst_out_data",   {12'd0, out_data},   64'd0);
        check_vec("rst_out_mask",   {12'd0, out_mask},   64'd0);
        check_vec("rst_mask_armed", {63'd0, mask_armed}, 64'd0);
        check_vec("rst_trng_ready", {63'd0, trng_ready}, 64'd1);
        check_vec("rst_in_ready",   {63'd0, in_ready},   64'd0);
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        // Fill and first masked transfer
        trng_valid = 1'b1;
        trng       = 32'hDEADBEEF;
        step();
        check_vec("t1_half_armed",    {63'd0, mask_armed}, 64'd0);
        check_vec("t1_half_in_ready", {63'd0, in_ready},   64'd0);
        trng = 32'h000A5A5A;
        step();
        trng_valid = 1'b0;
        check_vec("t1_armed",      {63'd0, mask_armed}, 64'd1);
        check_vec("t1_trng_ready", {63'd0, trng_ready}, 64'd0);
        check_vec("t1_in_ready",   {63'd0, in_ready},   64'd1);
        in_valid = 1'b1;
        in_data  = '0;
        step();
        in_valid = 1'b0;
        check_vec("t1_out_valid", {63'd0, out_valid},  64'd1);
        check_vec("t1_out_data",  {12'd0, out_data},   {12'd0, M1});
        check_vec("t1_out_mask",  {12'd0, out_mask},   {12'd0, M1});
        check_vec("t1_refill",    {63'd0, mask_armed}, 64'd0);
        check_vec("t1_in_ready0", {63'd0, in_ready},   64'd0);

        // Same mask refilled, all-ones data
        fill0(32'hDEADBEEF, 32'h000A5A5A);
        check_vec("t2_out_cleared", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b1;
        in_data  = 52'hFFFFFFFFFFFFF;
        step();
        in_valid = 1'b0;
        check_vec("t2_out_data", {12'd0, out_data},   64'h0005A5A521524110);
        check_vec("t2_fill",     {63'd0, mask_armed}, 64'd0);

        // Bypass keeps the mask use, then a masked transfer on the same mask
        fill0(32'h11111111, 32'h00022222);
        in_bypass = 1'b1;
        in_valid  = 1'b1;
        in_data   = 52'h123456789ABCD;
        step();
        check_vec("t3_byp_data",  {12'd0, out_data},   64'h000123456789ABCD);
        check_vec("t3_byp_mask",  {12'd0, out_mask},   64'd0);
        check_vec("t3_byp_armed", {63'd0, mask_armed}, 64'd1);
        in_bypass = 1'b0;
        step();
        in_valid = 1'b0;
        check_vec("t3_msk_data", {12'd0, out_data}, 64'h000301677698BADC);
        check_vec("t3_msk_mask", {12'd0, out_mask}, {12'd0, M3});

        // Output held under backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_vec("t4_bp_valid", {63'd0, out_valid}, 64'd1);
            check_vec("t4_bp_data",  {12'd0, out_data},  64'h000301677698BADC);
            check_vec("t4_bp_mask",  {12'd0, out_mask},  {12'd0, M3});
        end
        out_ready = 1'b1;
        step();
        check_vec("t4_bp_release", {63'd0, out_valid}, 64'd0);

        // Reset mid-fill discards the partial mask
        trng_valid = 1'b1;
        trng       = 32'hAAAAAAAA;
        step();
        trng_valid = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n = 1'b1;
        check_vec("t5_out_valid",  {63'd0, out_valid},  64'd0);
        check_vec("t5_out_data",   {12'd0, out_data},   64'd0);
        check_vec("t5_trng_ready", {63'd0, trng_ready}, 64'd1);
        trng_valid = 1'b1;
        trng       = 32'h00000001;
        step();
        check_vec("t5_one_beat", {63'd0, mask_armed}, 64'd0);
        trng = 32'h00000002;
        step();
        trng_valid = 1'b0;
        check_vec("t5_two_beats", {63'd0, mask_armed}, 64'd1);
        in_valid = 1'b1;
        in_data  = '0;
        step();
        in_valid = 1'b0;
        check_vec("t5_mask", {12'd0, out_mask}, 64'h0000200000001);

        // MASK_REUSE=4: back-to-back transfers at full throughput
        fill4(32'h12345678, 32'h0009ABCD);
        check_vec("r4_armed", {63'd0, mask4_armed}, 64'd1);
        in4_valid = 1'b1;
        in4_data  = 52'h7;
        step();
        check_vec("r4_d0",    {12'd0, out4_data},  {12'd0, M4 ^ 52'h7});
        check_vec("r4_v0",    {63'd0, out4_valid}, 64'd1);
`ifdef DATA_MASK_PARITY_EN
        check_vec("r4_par7",  {63'd0, out4_parity}, 64'd1);
`endif
        in4_data = 52'h3;
        step();
        check_vec("r4_d1",    {12'd0, out4_data},  {12'd0, M4 ^ 52'h3});
        check_vec("r4_m1",    {12'd0, out4_mask},  {12'd0, M4});
`ifdef DATA_MASK_PARITY_EN
        check_vec("r4_par3",  {63'd0, out4_parity}, 64'd0);
`endif
        in4_data = 52'h1;
        step();
        check_vec("r4_d2",    {12'd0, out4_data},   {12'd0, M4 ^ 52'h1});
        check_vec("r4_arm2",  {63'd0, mask4_armed}, 64'd1);
        in4_data = 52'h0;
        step();
        in4_valid = 1'b0;
        check_vec("r4_d3",    {12'd0, out4_data},   {12'd0, M4});
        check_vec("r4_v3",    {63'd0, out4_valid},  64'd1);
        check_vec("r4_fill",  {63'd0, mask4_armed}, 64'd0);
        check_vec("r4_inrdy", {63'd0, in4_ready},   64'd0);

        // MASK_REUSE=4: backpressure while armed stalls input, then no bubble
        fill4(32'h12345678, 32'h0009ABCD);
        in4_valid = 1'b1;
        in4_data  = 52'hFF;
        step();
        check_vec("r4_bp_first", {12'd0, out4_data}, {12'd0, M4 ^ 52'hFF});
        out4_ready = 1'b0;
        in4_data   = 52'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec("r4_bp_data",  {12'd0, out4_data},   {12'd0, M4 ^ 52'hFF});
            check_vec("r4_bp_inrdy", {63'd0, in4_ready},   64'd0);
            check_vec("r4_bp_armed", {63'd0, mask4_armed}, 64'd1);
        end
        out4_ready = 1'b1;
        step();
        in4_valid = 1'b0;
        check_vec("r4_bp_next",  {12'd0, out4_data},  {12'd0, M4 ^ 52'hEE});
        check_vec("r4_bp_valid", {63'd0, out4_valid}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
